pwm_ramp_ctl: RTL

- Command stage directly upstream of the PWM generator; drives its en, numerator and denominator.
- Accepts a target duty (numerator) and period (denominator) through a valid/ready handshake.
- Slews numerator linearly toward the target in programmable steps at a programmable tick rate.
- On stop, ramps numerator down to zero, then deasserts en, so the driven load never sees a duty step larger than one step.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_tick_gen.sv | 34 +++
 rtl/pwm_ramp_ctl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its command/ramp stage.
package pwm_pkg;

    localparam int unsigned PWM_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_DECEL
    } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Interval prescaler: fires one tick every interval+1 cycles while run is high.
module pwm_tick_gen #(
    parameter int unsigned C_TICK_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    run,
    input  logic [C_TICK_WIDTH-1:0] interval,
    output logic                    tick
);

    localparam logic [C_TICK_WIDTH-1:0] ONE = C_TICK_WIDTH'(1);

    logic [C_TICK_WIDTH-1:0] cnt_q;
    logic [C_TICK_WIDTH-1:0] cnt_d;

    assign tick = run && (cnt_q == interval);

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctl.sv
// Command stage ahead of the PWM generator: accepts duty/period commands and
// slews the numerator toward the target, ramping to zero before disabling.
module pwm_ramp_ctl
    import pwm_pkg::*;
#(
    parameter int unsigned C_PWM_CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int unsigned C_STEP_WIDTH    = 8,
    parameter int unsigned C_TICK_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [C_PWM_CNT_WIDTH-1:0] s_target,
    input  logic [C_PWM_CNT_WIDTH-1:0] s_denominator,
    input  logic [C_STEP_WIDTH-1:0]    step,
    input  logic [C_TICK_WIDTH-1:0]    interval,
    input  logic                       stop,
    output logic                       en,
    output logic [C_PWM_CNT_WIDTH-1:0] numerator,
    output logic [C_PWM_CNT_WIDTH-1:0] denominator,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned W  = C_PWM_CNT_WIDTH;
    localparam int unsigned WX = C_PWM_CNT_WIDTH + 1;

    pwm_state_e state_q, state_d;
    logic         en_q, en_d;
    logic [W-1:0] num_q, num_d;
    logic [W-1:0] den_q, den_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic         done_q, done_d;

    logic          accept;
    logic          run;
    logic          tick;
    logic [W-1:0]  tgt_clamp;
    logic [W-1:0]  num_clamp;
    logic [WX-1:0] step_x;
    logic [W-1:0]  step_n;
    logic          ramp_up;
    logic [WX-1:0] diff_x;
    logic          ramp_snap;
    logic          decel_snap;

    assign s_ready = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !stop;
    assign accept  = s_valid && s_ready;

    // Stop in RAMP holds the prescaler at 0 for that cycle so DECEL starts a fresh interval.
    assign run = ((state_q == ST_RAMP) && !stop) || (state_q == ST_DECEL);

    pwm_tick_gen #(
        .C_TICK_WIDTH(C_TICK_WIDTH)
    ) u_tick (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .interval(interval),
        .tick    (tick)
    );

    assign tgt_clamp = (s_target > s_denominator) ? s_denominator : s_target;
    assign num_clamp = (num_q > s_denominator) ? s_denominator : num_q;

    assign step_x     = WX'(step);
    assign step_n     = W'(step);
    assign ramp_up    = (tgt_q >= num_q);
    assign diff_x     = ramp_up ? ({1'b0, tgt_q} - {1'b0, num_q})
                                : ({1'b0, num_q} - {1'b0, tgt_q});
    assign ramp_snap  = (step_x == '0) || (diff_x <= step_x);
    assign decel_snap = (step_x == '0) || ({1'b0, num_q} <= step_x);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        num_d   = num_q;
        den_d   = den_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    den_d = s_denominator;
                    tgt_d = tgt_clamp;
                    num_d = '0;
                    en_d  = 1'b1;
                    if (tgt_clamp == '0) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_DECEL;
                    tgt_d   = '0;
                end else if (accept) begin
                    den_d = s_denominator;
                    tgt_d = tgt_clamp;
                    num_d = num_clamp;
                    if (num_clamp == tgt_clamp) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    state_d = ST_DECEL;
                    tgt_d   = '0;
                end else if (tick) begin
                    if (ramp_snap) begin
                        num_d   = tgt_q;
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else if (ramp_up) begin
                        num_d = num_q + step_n;
                    end else begin
                        num_d = num_q - step_n;
                    end
                end
            end
            ST_DECEL: begin
                if (num_q == '0) begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    num_d = decel_snap ? '0 : (num_q - step_n);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            num_q   <= num_d;
            den_q   <= den_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign en          = en_q;
    assign numerator   = num_q;
    assign denominator = den_q;
    assign busy        = (state_q == ST_RAMP) || (state_q == ST_DECEL);
    assign done        = done_q;

endmodule
